// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM state encoding, port id,
// and the largest supported memory latency.
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_e;

   typedef logic port_t;

   localparam int unsigned MAX_LAT = 15;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker. Purely combinational; the caller owns
// the last-served pointer and decides when it advances.
module rr_arb2
   import dmem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  port_t      last,
   output port_t      grant,
   output logic       valid
);

   // Single requester wins outright; on contention favour the one not served last
   always_comb begin
      valid = |req;
      grant = 1'b0;
      case (req)
         2'b01:   grant = 1'b0;
         2'b10:   grant = 1'b1;
         2'b11:   grant = ~last;
         default: grant = 1'b0;
      endcase
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of a single-port, strobe-triggered
// data memory: round-robin grant, one-cycle registered strobes, fixed
// MEM_LAT wait, one-cycle done pulse with read data.
// Optional macro DMEM_ARB_ALIGN_CHECK_EN adds p0_err/p1_err and rejects
// accesses with addr[1:0] != 0 without touching memory.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned AW      = 32,
   parameter int unsigned DW      = 32,
   parameter int unsigned MEM_LAT = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          p0_req,
   input  logic          p0_we,
   input  logic [AW-1:0] p0_addr,
   input  logic [DW-1:0] p0_wdata,
   output logic [DW-1:0] p0_rdata,
   output logic          p0_done,
   input  logic          p1_req,
   input  logic          p1_we,
   input  logic [AW-1:0] p1_addr,
   input  logic [DW-1:0] p1_wdata,
   output logic [DW-1:0] p1_rdata,
   output logic          p1_done,
   output logic [AW-1:0] mem_address,
   output logic [DW-1:0] mem_write_data,
   output logic          mem_read,
   output logic          mem_write,
   input  logic [DW-1:0] mem_read_data,
`ifdef DMEM_ARB_ALIGN_CHECK_EN
   output logic          p0_err,
   output logic          p1_err,
`endif
   output logic          busy
);

   localparam int unsigned   CW     = $clog2(MAX_LAT + 1);
   localparam logic [CW-1:0] LAT_M1 = CW'(MEM_LAT - 1);

   state_e        state_q, state_d;
   port_t         port_q, port_d;
   logic          we_q, we_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [CW-1:0] cnt_q, cnt_d;
   port_t         rr_ptr_q, rr_ptr_d;
   logic          served_q, served_d;
   logic          mem_read_q, mem_read_d;
   logic          mem_write_q, mem_write_d;
   logic [DW-1:0] p0_rdata_q, p0_rdata_d;
   logic [DW-1:0] p1_rdata_q, p1_rdata_d;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
   logic          err_q, err_d;
`endif

   port_t         arb_grant;
   logic          arb_valid;
   port_t         arb_last;
   logic          sel_we;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdata;
   logic          misalign;

   // rr_ptr resets to 0 yet port 0 must win the first contention, so until
   // something has been served the picker is told port 1 went last.
   assign arb_last = served_q ? rr_ptr_q : 1'b1;

   rr_arb2 u_rr_arb2 (
      .req   ({p1_req, p0_req}),
      .last  (arb_last),
      .grant (arb_grant),
      .valid (arb_valid)
   );

   // Select the granted port's request fields
   always_comb begin
      sel_we    = arb_grant ? p1_we    : p0_we;
      sel_addr  = arb_grant ? p1_addr  : p0_addr;
      sel_wdata = arb_grant ? p1_wdata : p0_wdata;
   end

`ifdef DMEM_ARB_ALIGN_CHECK_EN
   assign misalign = (sel_addr[1:0] != 2'b00);
`else
   assign misalign = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (arb_valid) state_d = misalign ? RESP : ISSUE;
         ISSUE:   state_d = WAIT;
         WAIT:    if (cnt_q == '0) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Transaction latch, wait counter, pointer and per-port read data
   always_comb begin
      port_d     = port_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      cnt_d      = cnt_q;
      rr_ptr_d   = rr_ptr_q;
      served_d   = served_q;
      p0_rdata_d = p0_rdata_q;
      p1_rdata_d = p1_rdata_q;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
      err_d      = err_q;
`endif
      case (state_q)
         IDLE: if (arb_valid) begin
            port_d  = arb_grant;
            we_d    = sel_we;
            addr_d  = sel_addr;
            wdata_d = sel_wdata;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
            err_d   = misalign;
`endif
         end
         ISSUE: cnt_d = LAT_M1;
         WAIT: begin
            // Read data is captured on the edge entering RESP so it is
            // already valid while done is high.
            if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
            else if (!we_q) begin
               if (port_q) p1_rdata_d = mem_read_data;
               else        p0_rdata_d = mem_read_data;
            end
         end
         RESP: begin
            rr_ptr_d = port_q;
            served_d = 1'b1;
         end
         default: ;
      endcase
   end

   // Datapath and strobe registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         port_q      <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         cnt_q       <= '0;
         rr_ptr_q    <= 1'b0;
         served_q    <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         p0_rdata_q  <= '0;
         p1_rdata_q  <= '0;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
         err_q       <= 1'b0;
`endif
      end else begin
         port_q      <= port_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         cnt_q       <= cnt_d;
         rr_ptr_q    <= rr_ptr_d;
         served_q    <= served_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         p0_rdata_q  <= p0_rdata_d;
         p1_rdata_q  <= p1_rdata_d;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
         err_q       <= err_d;
`endif
      end
   end

   // Outputs: strobes registered from the next state, status decoded from state
   always_comb begin
      mem_read_d     = (state_d == ISSUE) && !we_d;
      mem_write_d    = (state_d == ISSUE) &&  we_d;
      mem_read       = mem_read_q;
      mem_write      = mem_write_q;
      mem_address    = addr_q;
      mem_write_data = wdata_q;
      p0_rdata       = p0_rdata_q;
      p1_rdata       = p1_rdata_q;
      busy           = (state_q != IDLE);
      p0_done        = (state_q == RESP) && !port_q;
      p1_done        = (state_q == RESP) &&  port_q;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
      p0_err         = p0_done && err_q;
      p1_err         = p1_done && err_q;
`endif
   end

endmodule
